// File: rtl/mux8_scan_seq_pkg.sv
// rtl/mux8_scan_seq_pkg.sv - shared constants and FSM state encoding for the 8:1 mux scanner
package mux8_scan_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;
  localparam int CNTW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mux8_scan_seq_if.sv
// rtl/mux8_scan_seq_if.sv - handshake, mask, select and capture signals of the mux scanner
interface mux8_scan_seq_if;
  import mux8_scan_pkg::*;

  logic            START;
  logic            ABORT;
  logic [NCH-1:0]  MASK;
  logic            Z;
  logic            SD1;
  logic            SD2;
  logic            SD3;
  logic [NCH-1:0]  Q;
  logic            BUSY;
  logic            DONE;

  // upstream controller plus the downstream mux returning Z
  modport master (
    output START, ABORT, MASK, Z,
    input  SD1, SD2, SD3, Q, BUSY, DONE
  );

  // the sequencer itself
  modport slave (
    input  START, ABORT, MASK, Z,
    output SD1, SD2, SD3, Q, BUSY, DONE
  );

endinterface

// File: rtl/mux8_scan_seq_next_chan.sv
// rtl/mux8_scan_seq_next_chan.sv - priority encoder picking the next enabled channel
module mux8_next_chan
  import mux8_scan_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] sel,
  input  logic            from_start,
  output logic [SELW-1:0] next_sel,
  output logic            valid
);

  // lowest enabled channel at or above 0 (from_start) or strictly above sel
  always_comb begin
    next_sel = '0;
    valid    = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(sel)))) begin
        next_sel = SELW'(i);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_scan_seq.sv
// rtl/mux8_scan_seq.sv - masked 8-channel bit scanner driving the select lines of an 8:1 mux
module mux8_scan_seq
  import mux8_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic           CK,
  input  logic           RSTN,
  mux8_scan_seq_if.slave bus
);

  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q;
  logic [CNTW-1:0] cnt_q;
  logic [NCH-1:0]  mask_q;
  logic [NCH-1:0]  q_q;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic            capture;
  logic [NCH-1:0]  nc_mask;
  logic [SELW-1:0] nc_sel;
  logic            nc_valid;

  // START is only looked at when no scan is running (IDLE or FIN)
  assign accept  = (state_q != SCAN) && bus.START;
  // ABORT takes priority over a capture falling on the same edge
  assign capture = (state_q == SCAN) && !bus.ABORT && (cnt_q == SETTLE_LAST);
  // on acceptance the search runs over the incoming mask, otherwise the latched one
  assign nc_mask = accept ? bus.MASK : mask_q;

  mux8_next_chan u_next_chan (
    .mask       (nc_mask),
    .sel        (sel_q),
    .from_start (accept),
    .next_sel   (nc_sel),
    .valid      (nc_valid)
  );

  // state register plus the registered BUSY/DONE flags
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FIN: begin
        if (bus.START) begin
          state_d = nc_valid ? SCAN : FIN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (bus.ABORT) begin
          state_d = IDLE;
        end else if (capture && !nc_valid) begin
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are decoded from the next state so they leave the block from flops
  always_comb begin
    busy_d = (state_d == SCAN);
    done_d = (state_d == FIN);
  end

  // select, settle counter, latched mask and capture word
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
      q_q    <= '0;
    end else if (accept) begin
      mask_q <= bus.MASK;
      q_q    <= '0;
      cnt_q  <= '0;
      if (nc_valid) begin
        sel_q <= nc_sel;
      end
    end else if ((state_q == SCAN) && !bus.ABORT) begin
      if (capture) begin
        q_q[sel_q] <= bus.Z;
        cnt_q      <= '0;
        if (nc_valid) begin
          sel_q <= nc_sel;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.SD1  = sel_q[0];
  assign bus.SD2  = sel_q[1];
  assign bus.SD3  = sel_q[2];
  assign bus.Q    = q_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule
